// File: rtl/vec_engine_pkg.sv
// Shared enumerations for the vector engine: operation modes and control FSM states.
package vec_engine_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_MUL  = 2'b01,
    MODE_DOT  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_CALC  = 2'b10,
    ST_FIN   = 2'b11
  } state_e;

endpackage

// File: rtl/vec_engine_alu.sv
// Shared arithmetic: one multiplier and one adder, with the adder operands steered for DOT.
module vec_engine_alu #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] acc,
  input  logic              dot_sel,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] prod
);

  logic [DATA_W-1:0] add_x;
  logic [DATA_W-1:0] add_y;

  // DOT reuses the adder as the accumulator: acc + a*b instead of a + b.
  assign prod  = a * b;
  assign add_x = dot_sel ? acc  : a;
  assign add_y = dot_sel ? prod : b;
  assign sum   = add_x + add_y;

endmodule

// File: rtl/vec_engine.sv
// Vector engine: loads A/B vectors, runs ADD/MUL into C or DOT into dot_out, one element per two cycles.
module vec_engine
  import vec_engine_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              category,
  input  logic [ADDR_W-1:0] index,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W:0]   n,
  input  logic [ADDR_W-1:0] rd_index,
  output logic [DATA_W-1:0] c_data_out,
  output logic [DATA_W-1:0] dot_out,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_I = ADDR_W'(1);

  // Run handshake: start is taken only on an IDLE edge (busy=0); busy stays high from that
  // edge through FIN, and done rises on the FIN->IDLE edge and holds until the next accepted start.

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [ADDR_W:0]   n_eff_q;
  logic [ADDR_W-1:0] i_q;
  logic [DATA_W-1:0] acc_q, a_q, b_q;
  logic [DATA_W-1:0] alu_sum, alu_prod;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] mem_c [DEPTH];

  logic [ADDR_W:0] n_eff;
  logic            run_empty;
  logic            last_elem;

  assign n_eff     = (n > DEPTH_N) ? DEPTH_N : n;
  assign run_empty = (n_eff == '0) || (mode == MODE_RSVD);
  assign last_elem = ({1'b0, i_q} == (n_eff_q - ONE_N));
  assign dbg_state = state_q;

  vec_engine_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (a_q),
    .b       (b_q),
    .acc     (acc_q),
    .dot_sel (mode_q == MODE_DOT),
    .sum     (alu_sum),
    .prod    (alu_prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = run_empty ? ST_FIN : ST_FETCH;
      ST_FETCH: state_d = ST_CALC;
      ST_CALC:  state_d = last_elem ? ST_FIN : ST_FETCH;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_ADD;
      n_eff_q <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dot_out <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode_e'(mode);
            n_eff_q <= n_eff;
            i_q     <= '0;
            acc_q   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_FETCH: begin
          a_q <= mem_a[i_q];
          b_q <= mem_b[i_q];
        end
        ST_CALC: begin
          if (mode_q == MODE_DOT) acc_q <= alu_sum;
          if (!last_elem) i_q <= i_q + ONE_I;
        end
        ST_FIN: begin
          if (mode_q == MODE_DOT) dot_out <= acc_q;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Vector storage has no reset: contents survive a reset, including a partially written C.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && we) begin
      if (category) mem_b[index] <= b_data;
      else          mem_a[index] <= a_data;
    end
    if (state_q == ST_CALC && (mode_q == MODE_ADD || mode_q == MODE_MUL))
      mem_c[i_q] <= (mode_q == MODE_MUL) ? alu_prod : alu_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) c_data_out <= '0;
    else      c_data_out <= mem_c[rd_index];
  end

endmodule

// File: tb/tb_vec_engine.sv
// Self-checking bench for vec_engine against an array-based reference of the vector operations.
module tb_vec_engine;
  import vec_engine_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we = 1'b0;
  logic              category = 1'b0;
  logic [ADDR_W-1:0] index = '0;
  logic [DATA_W-1:0] a_data = '0;
  logic [DATA_W-1:0] b_data = '0;
  logic              start = 1'b0;
  logic [1:0]        mode = '0;
  logic [ADDR_W:0]   n = '0;
  logic [ADDR_W-1:0] rd_index = '0;
  logic [DATA_W-1:0] c_data_out;
  logic [DATA_W-1:0] dot_out;
  logic              busy;
  logic              done;
  state_e            dbg_state;

  vec_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .category   (category),
    .index      (index),
    .a_data     (a_data),
    .b_data     (b_data),
    .start      (start),
    .mode       (mode),
    .n          (n),
    .rd_index   (rd_index),
    .c_data_out (c_data_out),
    .dot_out    (dot_out),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ma [DEPTH];
  logic [DATA_W-1:0] mb [DEPTH];
  logic [DATA_W-1:0] mc [DEPTH];
  logic [DATA_W-1:0] model_dot = '0;
  logic [DATA_W-1:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_run(input int m, input int neff);
    logic [DATA_W-1:0] acc;
    acc = '0;
    if (m == 3) return;
    for (int k = 0; k < neff; k++) begin
      if (m == 0) mc[k] = ma[k] + mb[k];
      else if (m == 1) mc[k] = ma[k] * mb[k];
      else acc = acc + ma[k] * mb[k];
    end
    if (m == 2) model_dot = acc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic cat, input int idx, input logic [DATA_W-1:0] val);
    we = 1'b1;
    category = cat;
    index = ADDR_W'(idx);
    if (cat) b_data = val;
    else     a_data = val;
    step();
    we = 1'b0;
    if (cat) mb[idx] = val;
    else     ma[idx] = val;
  endtask

  task automatic read_c(input string tag, input int idx);
    rd_index = ADDR_W'(idx);
    exp_q.push_back(mc[idx]);
    step();
    check(tag, c_data_out, exp_q.pop_front());
  endtask

  // Runs one operation; with disturb set, pulses we and start while the engine is busy.
  task automatic run(input int m, input int nn, input bit disturb);
    int neff, exp_lat, cnt;
    neff    = (nn > DEPTH) ? DEPTH : nn;
    exp_lat = (m == 3 || neff == 0) ? 1 : 2 * neff + 1;
    mode  = 2'(m);
    n     = (ADDR_W + 1)'(nn);
    start = 1'b1;
    step();
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    n     = (ADDR_W + 1)'($urandom);
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    cnt = 0;
    while (!done && cnt < 5000) begin
      if (disturb && cnt == 2) begin
        we       = 1'b1;
        category = 1'($urandom);
        index    = '0;
        a_data   = $urandom;
        b_data   = $urandom;
        start    = 1'b1;
      end
      if (disturb && cnt == 4) begin
        we    = 1'b0;
        start = 1'b0;
      end
      step();
      cnt++;
    end
    check("done_latency", cnt, exp_lat);
    check("busy_at_done", busy, 0);
    model_run(m, neff);
    check("dot_out", dot_out, model_dot);
    step();
    check("done_hold", done, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int neff, m, nn;
    repeat (3) step();
    check("rst_c_data_out", c_data_out, 0);
    check("rst_dot_out", dot_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    step();

    // Fill every element, then a clamped full-depth ADD (largest encodable n is 2047).
    for (int k = 0; k < DEPTH; k++) begin
      load(1'b0, k, $urandom);
      load(1'b1, k, $urandom);
    end
    run(0, 2047, 1'b0);
    read_c("clamp_c_first", 0);
    read_c("clamp_c_last", DEPTH - 1);
    for (int k = 0; k < 4; k++) read_c("clamp_c_rand", $urandom_range(0, DEPTH - 1));

    // Directed ADD and DOT on 1..4 / 10..40.
    for (int k = 0; k < 4; k++) begin
      load(1'b0, k, DATA_W'(k + 1));
      load(1'b1, k, DATA_W'(10 * (k + 1)));
    end
    run(0, 4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      read_c("add_c", k);
      check("add_c_const", c_data_out, DATA_W'(11 * (k + 1)));
    end
    run(2, 4, 1'b0);
    check("dot_300", dot_out, 300);
    for (int k = 0; k < 4; k++) read_c("dot_c_unchanged", k);

    // MUL wrap.
    load(1'b0, 0, 32'hFFFF_FFFF);
    load(1'b1, 0, 32'd2);
    run(1, 1, 1'b0);
    read_c("mul_wrap", 0);
    check("mul_wrap_const", c_data_out, 32'hFFFF_FFFE);

    // Degenerate runs: no C writes, reserved mode leaves dot_out alone.
    run(0, 0, 1'b0);
    run(3, 5, 1'b0);
    read_c("degen_c0", 0);
    read_c("degen_c1", 1);

    // we/start pulsed mid-run are ignored; a DOT over the same span confirms A/B intact.
    run(0, 6, 1'b1);
    for (int k = 0; k < 6; k++) read_c("busy_ignore_c", k);
    run(2, 6, 1'b0);

    // Reset while computing element 2.
    rd_index = 2;
    step();
    for (int k = 0; k < 4; k++) begin
      load(1'b0, k, $urandom);
      load(1'b1, k, $urandom);
    end
    mode  = 2'(0);
    n     = (ADDR_W + 1)'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("pre_reset_state", dbg_state, ST_CALC);
    rst = 1'b0;
    #1;
    check("mid_rst_c_data_out", c_data_out, 0);
    check("mid_rst_dot_out", dot_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    mc[0] = ma[0] + mb[0];
    mc[1] = ma[1] + mb[1];
    model_dot = '0;
    step();
    rst = 1'b1;
    step();
    read_c("rst_keep_c0", 0);
    read_c("rst_keep_c1", 1);
    read_c("rst_old_c2", 2);

    // Randomized runs against the model.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 4; k++) load(1'($urandom), $urandom_range(0, 15), $urandom);
      m  = $urandom_range(0, 3);
      nn = $urandom_range(0, 12);
      neff = nn;
      run(m, nn, 1'b0);
      for (int k = 0; k <= ((neff < 4) ? neff : 4); k++) read_c("rand_c", k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
